// File: rtl/rom_image_loader.sv
// rom_image_loader: copies the HPS ioctl byte stream into a ROM image
// through a ready/valid write port and holds the CPU until it is loaded.
module rom_image_loader #(
    parameter int         widthad_a     = 14,
    parameter int         width_a       = 8,
    parameter logic [7:0] INDEX         = 8'd0,
    parameter int         RELEASE_DELAY = 16
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 ioctl_download,
    input  logic [7:0]           ioctl_index,
    input  logic                 ioctl_wr,
    input  logic [24:0]          ioctl_addr,
    input  logic [7:0]           ioctl_dout,
    output logic                 ioctl_wait,
    output logic                 mem_we,
    input  logic                 mem_ready,
    output logic [widthad_a-1:0] mem_address,
    output logic [width_a-1:0]   mem_data,
    output logic                 cpu_hold,
    output logic                 loaded,
    output logic                 overflow,
    output logic [widthad_a:0]   byte_count,
    output logic [15:0]          checksum
);

    localparam int DW = (RELEASE_DELAY > 1) ? $clog2(RELEASE_DELAY) : 1;
    localparam logic [widthad_a:0] CAP = {1'b1, {widthad_a{1'b0}}};
    localparam logic [DW-1:0] DLY_LOAD = DW'(RELEASE_DELAY - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_WRITE,
        S_FINISH
    } state_t;

    state_t                 r_state;
    logic [DW-1:0]          r_delay;
    logic                   r_ioctl_wait;
    logic                   r_mem_we;
    logic [widthad_a-1:0]   r_mem_address;
    logic [width_a-1:0]     r_mem_data;
    logic                   r_cpu_hold;
    logic                   r_loaded;
    logic                   r_overflow;
    logic [widthad_a:0]     r_byte_count;
    logic [15:0]            r_checksum;

    logic                   w_accept;
    logic                   w_in_range;
    logic [widthad_a:0]     w_count_inc;
    logic [15:0]            w_sum_inc;

    assign w_accept    = ioctl_download && (ioctl_index == INDEX);
    assign w_in_range  = (ioctl_addr[24:widthad_a] == '0);
    assign w_count_inc = (r_byte_count == CAP) ? r_byte_count
                       : r_byte_count + (widthad_a + 1)'(1);
    assign w_sum_inc   = r_checksum + 16'(r_mem_data);

    // Download sequencer: byte intake, write handshake and CPU release timing
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= S_IDLE;
            r_delay       <= '0;
            r_ioctl_wait  <= 1'b0;
            r_mem_we      <= 1'b0;
            r_mem_address <= '0;
            r_mem_data    <= '0;
            r_cpu_hold    <= 1'b0;
            r_loaded      <= 1'b0;
            r_overflow    <= 1'b0;
            r_byte_count  <= '0;
            r_checksum    <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_state      <= S_LOAD;
                        r_cpu_hold   <= 1'b1;
                        r_loaded     <= 1'b0;
                        r_overflow   <= 1'b0;
                        r_byte_count <= '0;
                        r_checksum   <= '0;
                    end
                end
                S_LOAD: begin
                    if (ioctl_wr) begin
                        if (w_in_range) begin
                            r_mem_address <= ioctl_addr[widthad_a-1:0];
                            r_mem_data    <= width_a'(ioctl_dout);
                            r_mem_we      <= 1'b1;
                            r_ioctl_wait  <= 1'b1;
                            r_state       <= S_WRITE;
                        end else begin
                            r_overflow <= 1'b1;
                        end
                    end else if (!ioctl_download) begin
                        r_delay <= DLY_LOAD;
                        r_state <= S_FINISH;
                    end
                end
                S_WRITE: begin
                    if (mem_ready) begin
                        r_mem_we     <= 1'b0;
                        r_ioctl_wait <= 1'b0;
                        r_byte_count <= w_count_inc;
                        r_checksum   <= w_sum_inc;
                        if (ioctl_download) begin
                            r_state <= S_LOAD;
                        end else begin
                            r_delay <= DLY_LOAD;
                            r_state <= S_FINISH;
                        end
                    end
                end
                S_FINISH: begin
                    if (w_accept) begin
                        r_state      <= S_LOAD;
                        r_overflow   <= 1'b0;
                        r_byte_count <= '0;
                        r_checksum   <= '0;
                    end else if (r_delay == '0) begin
                        r_cpu_hold <= 1'b0;
                        r_loaded   <= 1'b1;
                        r_state    <= S_IDLE;
                    end else begin
                        r_delay <= r_delay - DW'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign ioctl_wait  = r_ioctl_wait;
    assign mem_we      = r_mem_we;
    assign mem_address = r_mem_address;
    assign mem_data    = r_mem_data;
    assign cpu_hold    = r_cpu_hold;
    assign loaded      = r_loaded;
    assign overflow    = r_overflow;
    assign byte_count  = r_byte_count;
    assign checksum    = r_checksum;

endmodule

// File: doc/rom_image_loader.md
Name: rom_image_loader

Overview:
- Writer-side counterpart to the team's synchronous single-port ROM.
- Accepts a byte stream from the HPS ioctl download interface and writes it into a RAM-backed ROM image (width_a x 2**widthad_a) through a ready/valid write port.
- Holds the CPU in reset while loading, then releases it after a programmable delay.
- Keeps a running byte count and a 16-bit additive checksum for debug/OSD.

Parameters:
- widthad_a, 14, address width of target memory; capacity 2**widthad_a bytes
- width_a, 8, data width; only 8 is supported
- INDEX, 0, ioctl_index value this loader accepts
- RELEASE_DELAY, 16, cycles cpu_hold stays high after download ends (>=1)

Ports:
- clock  in  1  system clock, all logic on rising edge
- reset_n  in  1  asynchronous active-low reset
- ioctl_download  in  1  HPS download active
- ioctl_index  in  8  download target selector
- ioctl_wr  in  1  single-cycle byte strobe
- ioctl_addr  in  25  byte address of ioctl_dout
- ioctl_dout  in  8  byte data
- ioctl_wait  out  1  stall request to HPS
- mem_we  out  1  write request (valid)
- mem_ready  in  1  memory accepts write when high with mem_we
- mem_address  out  widthad_a  write address
- mem_data  out  width_a  write data
- cpu_hold  out  1  CPU reset/hold request
- loaded  out  1  image complete, sticky until next accepted download
- overflow  out  1  a byte addressed at or above 2**widthad_a was dropped
- byte_count  out  widthad_a+1  bytes written in current/last download
- checksum  out  16  sum of written bytes, mod 2**16

Behaviour:
- Reset (asynchronous, effective immediately): state IDLE; all outputs 0, including mem_we, ioctl_wait, cpu_hold, loaded, overflow, byte_count, checksum, mem_address, mem_data.
- All outputs are registered.
- States: IDLE, LOAD, WRITE, FINISH.
- IDLE:
  - ioctl_download=1 and ioctl_index==INDEX -> LOAD on the next edge.
  - On that edge: cpu_hold=1; loaded, overflow, byte_count, checksum cleared.
  - Downloads with another index are ignored; outputs unchanged.
- LOAD, ioctl_wr=1:
  - If ioctl_addr < 2**widthad_a: latch mem_address=ioctl_addr[widthad_a-1:0] and mem_data=ioctl_dout; set mem_we=1 and ioctl_wait=1 on the same edge; go to WRITE.
  - Otherwise drop the byte, set overflow=1, and stay in LOAD.
  - Latency: strobe sampled at edge N -> mem_we and ioctl_wait high from edge N+1.
- LOAD, ioctl_download=0 (and no ioctl_wr that cycle): go to FINISH.
- WRITE:
  - mem_we, mem_address and mem_data are held stable until an edge with mem_ready=1.
  - On that edge: mem_we=0, ioctl_wait=0, byte_count+1, checksum+=mem_data (wraps mod 2**16).
  - Then go to LOAD, or to FINISH if ioctl_download is already 0. A write in flight always completes before FINISH.
  - With mem_ready tied high: mem_we is high for exactly 1 cycle; ioctl_wait deasserts at N+2.
- ioctl_wr during WRITE is a protocol violation and is ignored; no state change and no counter change.
- Duplicate addresses are written again and counted again. No ordering check is made.
- FINISH:
  - Delay counter loads RELEASE_DELAY-1 on entry and decrements each cycle.
  - When the counter is 0: cpu_hold=0, loaded=1, go to IDLE.
  - If an accepted download (ioctl_download=1, ioctl_index==INDEX) starts during FINISH: go straight to LOAD with cpu_hold kept at 1, counters cleared, loaded stays 0.
- byte_count saturates at 2**widthad_a. checksum/byte_count hold their values after the download until the next accepted download.
- Reset mid-WRITE: mem_we drops asynchronously and the partial byte is not counted. The memory content is then undefined for that address.

Test Plan:
- Reset release, no activity -> all outputs 0 for 100 cycles; cpu_hold=0.
- INDEX=0, mem_ready=1, download bytes 0x01,0x02,0x03 at addr 0..2, then drop download -> three 1-cycle mem_we pulses at addr 0,1,2; each ioctl_wait pulse lasts 1 cycle; byte_count=3, checksum=0x0006; cpu_hold falls exactly RELEASE_DELAY cycles after FINISH entry; loaded=1.
- mem_ready held low 5 cycles on the first byte (0xA5 at addr 0x10) -> mem_we, mem_address=0x10 and mem_data=0xA5 stable for 6 cycles; ioctl_wait high the whole time; an extra ioctl_wr injected mid-stall is ignored; count then increments by 1.
- Write 0x4000 bytes of 0xFF then one byte at addr 0x4000 -> overflow=1, no mem_we for the last byte, byte_count=0x4000, checksum=0xC000.
- Download with ioctl_index=1 -> no mem_we, cpu_hold stays 0. New INDEX download started during FINISH -> cpu_hold never drops, byte_count restarts at 0.
- Assert reset_n=0 mid-WRITE with mem_ready=0 -> mem_we=0 and cpu_hold=0 before the next clock edge; state is IDLE after release.
